// File: rtl/maze_player_overlay.sv
// Player sprite overlay for the 96x64 RGB565 maze display.
// The button-driven movement is gated by a move tick. Walls are checked
// through a second maze-ROM read port. The sprite is composited onto the
// registered maze colour stream, which is then sent to the OLED driver.
module maze_player_overlay #(
    parameter int          SIZE          = 3,
    parameter int          MOVE_DIV      = 5_000_000,
    parameter int          START_X       = 4,
    parameter int          START_Y       = 4,
    parameter logic [15:0] PLAYER_COLOUR = 16'hF800,
    parameter logic [15:0] FLOOR_COLOUR  = 16'h0000,
    parameter logic [15:0] GOAL_COLOUR   = 16'h001F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic [12:0] pixel_index,
    input  logic [15:0] maze_data,
    output logic [12:0] probe_index,
    input  logic [15:0] probe_data,
    output logic [15:0] pixel_data,
    output logic [6:0]  player_x,
    output logic [5:0]  player_y,
    output logic        goal_reached
);
    // state  | meaning
    // IDLE   | waiting for a move tick with a valid in-bounds direction
    // ISSUE  | drive probe_index with leading-edge pixel k
    // WAIT   | maze ROM registers the probe lookup
    // CHECK  | classify probe_data: wall aborts, last pixel commits
    // COMMIT | step the player one pixel, fold in the goal flag

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;

    localparam logic [1:0] D_UP    = 2'd0;
    localparam logic [1:0] D_DOWN  = 2'd1;
    localparam logic [1:0] D_LEFT  = 2'd2;
    localparam logic [1:0] D_RIGHT = 2'd3;

    localparam int CW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam int KW = (SIZE > 1) ? $clog2(SIZE) : 1;

    logic [CW-1:0] tick_cnt;
    logic          tick;
    logic [2:0]    state;
    logic [1:0]    move_dir;
    logic [KW-1:0] k_cnt;
    logic          pend_goal;
    logic          req_valid;
    logic [1:0]    req_dir;
    logic [6:0]    edge_col;
    logic [6:0]    edge_row;
    logic [12:0]   edge_idx;
    logic [12:0]   pidx_d;
    logic          in_sprite;
    logic [12:0]   row_base;

    assign tick = (tick_cnt == CW'(MOVE_DIV - 1));

    // Free-running move tick divider.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // The highest-priority button is checked against the screen bounds.
    // A higher-priority button that is out of bounds does not fall through to a lower one.
    always_comb begin
        req_valid = 1'b0;
        req_dir   = D_UP;
        if (btn_up) begin
            req_dir   = D_UP;
            req_valid = (player_y != 6'd0);
        end else if (btn_down) begin
            req_dir   = D_DOWN;
            req_valid = (int'(player_y) + SIZE <= 63);
        end else if (btn_left) begin
            req_dir   = D_LEFT;
            req_valid = (player_x != 7'd0);
        end else if (btn_right) begin
            req_dir   = D_RIGHT;
            req_valid = (int'(player_x) + SIZE <= 95);
        end
    end

    // Leading-edge pixel k for the latched direction, flattened to row*96+col.
    always_comb begin
        edge_col = 7'(player_x);
        edge_row = 7'(player_y);
        case (move_dir)
            D_UP: begin
                edge_col = 7'(player_x) + 7'(k_cnt);
                edge_row = 7'(player_y) - 7'd1;
            end
            D_DOWN: begin
                edge_col = 7'(player_x) + 7'(k_cnt);
                edge_row = 7'(player_y) + 7'(SIZE);
            end
            D_LEFT: begin
                edge_col = 7'(player_x) - 7'd1;
                edge_row = 7'(player_y) + 7'(k_cnt);
            end
            default: begin
                edge_col = 7'(player_x) + 7'(SIZE);
                edge_row = 7'(player_y) + 7'(k_cnt);
            end
        endcase
        edge_idx = 13'(edge_row) * 13'd96 + 13'(edge_col);
    end

    // Move sequencer: probe each leading-edge pixel, then commit or abort.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            move_dir     <= D_UP;
            k_cnt        <= '0;
            pend_goal    <= 1'b0;
            probe_index  <= '0;
            player_x     <= 7'(START_X);
            player_y     <= 6'(START_Y);
            goal_reached <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (tick && req_valid) begin
                        move_dir  <= req_dir;
                        k_cnt     <= '0;
                        pend_goal <= 1'b0;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    probe_index <= edge_idx;
                    state       <= S_WAIT;
                end
                S_WAIT: begin
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    if (probe_data != FLOOR_COLOUR && probe_data != GOAL_COLOUR) begin
                        state <= S_IDLE;
                    end else begin
                        if (probe_data == GOAL_COLOUR) begin
                            pend_goal <= 1'b1;
                        end
                        if (k_cnt == KW'(SIZE - 1)) begin
                            state <= S_COMMIT;
                        end else begin
                            k_cnt <= k_cnt + 1'b1;
                            state <= S_ISSUE;
                        end
                    end
                end
                S_COMMIT: begin
                    case (move_dir)
                        D_UP:    player_y <= player_y - 6'd1;
                        D_DOWN:  player_y <= player_y + 6'd1;
                        D_LEFT:  player_x <= player_x - 7'd1;
                        default: player_x <= player_x + 7'd1;
                    endcase
                    goal_reached <= goal_reached | pend_goal;
                    state        <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Sprite hit test on the delayed index. Each sprite row covers a contiguous run of SIZE indices.
    always_comb begin
        in_sprite = 1'b0;
        row_base  = '0;
        for (int r = 0; r < SIZE; r++) begin
            row_base = (13'(player_y) + 13'(r)) * 13'd96 + 13'(player_x);
            if (pidx_d >= row_base && pidx_d < row_base + 13'(SIZE)) begin
                in_sprite = 1'b1;
            end
        end
        if (pidx_d >= 13'd6144) begin
            in_sprite = 1'b0;
        end
    end

    // Two-stage overlay pipeline aligned with the registered maze colour.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pidx_d     <= '0;
            pixel_data <= '0;
        end else begin
            pidx_d     <= pixel_index;
            pixel_data <= in_sprite ? PLAYER_COLOUR : maze_data;
        end
    end

endmodule

// File: tb/tb_maze_player_overlay.sv
// Directed bench for maze_player_overlay with SIZE=3 and MOVE_DIV=16.
// The bench models both maze-ROM ports as registered lookups.
module tb_maze_player_overlay;
    localparam int SIZE     = 3;
    localparam int MOVE_DIV = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic [12:0] pixel_index = '0;
    logic [15:0] maze_data = '0;
    logic [12:0] probe_index;
    logic [15:0] probe_data = '0;
    logic [15:0] pixel_data;
    logic [6:0]  player_x;
    logic [5:0]  player_y;
    logic        goal_reached;

    int          checks = 0;
    int          errors = 0;
    int          tb_cnt = 0;
    int          probe_mode = 0;
    logic [12:0] goal_idx = '0;

    maze_player_overlay #(
        .SIZE(SIZE), .MOVE_DIV(MOVE_DIV), .START_X(4), .START_Y(4),
        .PLAYER_COLOUR(16'hF800), .FLOOR_COLOUR(16'h0000), .GOAL_COLOUR(16'h001F)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .pixel_index(pixel_index), .maze_data(maze_data),
        .probe_index(probe_index), .probe_data(probe_data),
        .pixel_data(pixel_data), .player_x(player_x), .player_y(player_y),
        .goal_reached(goal_reached)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] maze_model(input logic [12:0] idx);
        int row, col;
        if (idx >= 13'd6144) return 16'h1234;
        row = int'(idx) / 96;
        col = int'(idx) % 96;
        if (row >= 3 && row <= 12 && col >= 3 && col <= 92) return 16'h0000;
        return 16'hFFFF;
    endfunction

    function automatic logic [15:0] probe_model(input logic [12:0] idx);
        if (probe_mode == 0) return maze_model(idx);
        if (probe_mode == 1) return 16'h001F;
        return (idx == goal_idx) ? 16'h001F : 16'hFFFF;
    endfunction

    // Registered ROM ports and a mirror of the tick divider used only for timing.
    always @(posedge clk) begin
        maze_data  <= maze_model(pixel_index);
        probe_data <= probe_model(probe_index);
        if (!rst_n) tb_cnt <= 0;
        else if (tb_cnt == MOVE_DIV - 1) tb_cnt <= 0;
        else tb_cnt <= tb_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        edges(2);
        rst_n = 1'b1;
    endtask

    // Returns at the negedge just after the edge that samples tick.
    task automatic wait_tick();
        int n = 0;
        while (tb_cnt != MOVE_DIV - 1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("tick_timeout", 1, 0);
        edges(1);
    endtask

    logic [12:0] ov_idx [8] = '{13'd388, 13'd390, 13'd580, 13'd391, 13'd676, 13'd5, 13'd6200, 13'd387};
    logic [15:0] ov_exp [8] = '{16'hF800, 16'hF800, 16'hF800, 16'h0000, 16'h0000, 16'hFFFF, 16'h1234, 16'h0000};

    initial begin
        // Test 1: reset values, then a tick with no button held
        rst_n = 1'b0;
        edges(2);
        chk("rst_x", player_x, 4);
        chk("rst_y", player_y, 4);
        chk("rst_pix", pixel_data, 0);
        chk("rst_goal", goal_reached, 0);
        chk("rst_probe", probe_index, 0);
        rst_n = 1'b1;
        wait_tick();
        edges(10);
        chk("nobtn_x", player_x, 4);
        chk("nobtn_y", player_y, 4);

        // Test 2: a move right probes column 7 at rows 4..6, then commits after 10 edges
        do_reset();
        btn_right = 1'b1;
        wait_tick();
        edges(1);  chk("right_probe0", probe_index, 391);
        edges(3);  chk("right_probe1", probe_index, 487);
        edges(3);  chk("right_probe2", probe_index, 583);
        edges(2);  chk("right_x_early", player_x, 4);
        edges(1);  chk("right_x", player_x, 5);
        chk("right_y", player_y, 4);
        btn_right = 1'b0;

        // Test 3: the first up move succeeds and the second hits a wall; left is handled the same way
        do_reset();
        btn_up = 1'b1;
        wait_tick();
        edges(10); chk("up1_y", player_y, 3);
        wait_tick();
        edges(1);  chk("up2_probe", probe_index, 196);
        edges(9);  chk("up2_y_blocked", player_y, 3);
        btn_up = 1'b0;
        btn_left = 1'b1;
        wait_tick();
        edges(10); chk("left1_x", player_x, 3);
        wait_tick();
        edges(1);  chk("left2_probe", probe_index, 290);
        edges(9);  chk("left2_x_blocked", player_x, 3);
        btn_left = 1'b0;

        // Test 4: when up and right are both held, up has priority
        do_reset();
        btn_up = 1'b1;
        btn_right = 1'b1;
        wait_tick();
        edges(10);
        chk("prio_y", player_y, 3);
        chk("prio_x", player_x, 4);
        btn_up = 1'b0;
        btn_right = 1'b0;

        // Test 5: goal-coloured probes set the sticky flag
        do_reset();
        probe_mode = 1;
        btn_down = 1'b1;
        wait_tick();
        edges(9);  chk("goal_pre", goal_reached, 0);
        edges(1);  chk("goal_y", player_y, 5);
        chk("goal_set", goal_reached, 1);
        probe_mode = 0;
        wait_tick();
        edges(10); chk("goal_y2", player_y, 6);
        chk("goal_sticky", goal_reached, 1);
        btn_down = 1'b0;
        do_reset();
        chk("goal_cleared", goal_reached, 0);
        probe_mode = 2;
        goal_idx = 13'd676;
        btn_down = 1'b1;
        wait_tick();
        edges(10);
        chk("partgoal_y", player_y, 4);
        chk("partgoal_flag", goal_reached, 0);
        btn_down = 1'b0;
        probe_mode = 0;

        // Test 6: overlay vectors, each observed two edges later
        do_reset();
        for (int i = 0; i < 8; i++) begin
            pixel_index = ov_idx[i];
            edges(2);
            chk($sformatf("ovl_%0d", ov_idx[i]), pixel_data, ov_exp[i]);
        end

        // Reset while the FSM is in WAIT aborts the move and restores every output
        probe_mode = 1;
        btn_down = 1'b1;
        wait_tick();
        edges(10); chk("pre_abort_goal", goal_reached, 1);
        btn_down = 1'b0;
        probe_mode = 0;
        btn_right = 1'b1;
        wait_tick();
        edges(1);  chk("abort_probe", probe_index, 487);
        rst_n = 1'b0;
        edges(1);
        chk("abort_x", player_x, 4);
        chk("abort_y", player_y, 4);
        chk("abort_probe_rst", probe_index, 0);
        chk("abort_goal", goal_reached, 0);
        chk("abort_pix", pixel_data, 0);
        rst_n = 1'b1;
        btn_right = 1'b0;
        edges(20);
        chk("post_abort_x", player_x, 4);
        chk("post_abort_y", player_y, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
